// File: rtl/parity_serial_pkg.sv
// ============================================================================
// Module  : parity_serial_pkg
// Brief   : Shared encodings and helpers for the parity-framed serial transmitter.
//           Honours macro PARITY_SERIAL_TX_PARITY_EN (parity bit in frame).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package parity_serial_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic TX_IDLE_LEVEL = 1'b1;

`ifdef PARITY_SERIAL_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_START  = S_START,
    ST_DATA   = S_DATA,
    ST_PARITY = S_PARITY,
    ST_STOP   = S_STOP
  } state_t;

  // Serial bit periods per frame: start + data + (parity) + stop.
  function automatic int frame_bits(input int data_w);
    return PARITY_EN ? data_w + 3 : data_w + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/parity_serial_bit_timer.sv
// ============================================================================
// Module  : parity_serial_bit_timer
// Brief   : Counts CLKS_PER_BIT cycles per serial bit; bit_end marks the last one.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_serial_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  generate
    if (CLKS_PER_BIT == 1) begin : g_single
      // Every cycle is a full bit time; the counter collapses away.
      assign bit_end = 1'b1;
    end else begin : g_count
      localparam int CW = $clog2(CLKS_PER_BIT);
      localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

      logic [CW-1:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (clear || cnt == LAST) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign bit_end = (cnt == LAST);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/parity_serial_tx.sv
// ============================================================================
// Module  : parity_serial_tx
// Brief   : LSB-first serial transmitter: start(0), data, parity, stop(1).
//           Parity bit present only when PARITY_SERIAL_TX_PARITY_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_serial_tx
  import parity_serial_pkg::*;
#(
  parameter int DATA_W       = 6,
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shift;
  logic              parity;
  logic [IDX_W-1:0]  bit_idx;
  logic              bit_end;
  logic              timer_clear;

  // Holding the timer in IDLE aligns every bit period to the accepting edge.
  assign timer_clear = (state == ST_IDLE);

  parity_serial_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shift   <= '0;
      parity  <= 1'b0;
      bit_idx <= '0;
      tx      <= TX_IDLE_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            shift   <= data_in;
            parity  <= (^data_in) ^ (ODD_PARITY != 0);
            bit_idx <= '0;
            tx      <= ~TX_IDLE_LEVEL;
            busy    <= 1'b1;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            tx    <= shift[0];
            shift <= shift >> 1;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_IDX) begin
              if (PARITY_EN) begin
                tx    <= parity;
                state <= ST_PARITY;
              end else begin
                tx    <= TX_IDLE_LEVEL;
                state <= ST_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            tx    <= TX_IDLE_LEVEL;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          tx    <= TX_IDLE_LEVEL;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_parity_serial_tx.sv
// ============================================================================
// Module  : tb_parity_serial_tx
// Brief   : Randomized self-checking bench for parity_serial_tx (even and odd
//           parity instances side by side). Macro PARITY_SERIAL_TX_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_serial_tx;

  localparam int DW  = 6;
  localparam int CPB = 4;
`ifdef PARITY_SERIAL_TX_PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  localparam int NBITS = PE ? DW + 3 : DW + 2;
  localparam int NCYC  = NBITS * CPB;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          load;
  logic          tx_e, busy_e, done_e;
  logic          tx_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
    .tx(tx_e), .busy(busy_e), .done(done_e)
  );

  parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .ODD_PARITY(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
    .tx(tx_o), .busy(busy_o), .done(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, obs, expv);
    end
  endtask

  // Reference frame: bit 0 start, data LSB first, optional parity, stop last.
  function automatic logic exp_bit(input logic [DW-1:0] d, input int idx, input bit odd);
    int ones;
    ones = 0;
    for (int k = 0; k < DW; k++) ones += int'(d[k]);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return d[idx-1];
    if (PE && idx == DW + 1) return odd ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
    return 1'b1;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load = 1'b0;
      @(posedge clk);
      #1;
      check("idle_tx", {tx_o, tx_e}, 2'b11);
      check("idle_busy", {busy_o, busy_e}, 2'b00);
      check("idle_done", {done_o, done_e}, 2'b00);
    end
  endtask

  // Sends one frame; hold keeps load high throughout, inject fires a
  // 6'b111111 load at cycle 10 of the frame.
  task automatic run_frame(input logic [DW-1:0] d, input bit hold, input bit inject);
    @(negedge clk);
    data_in = d;
    load    = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= NCYC; c++) begin
      check("tx_even", 32'(tx_e), 32'(exp_bit(d, (c - 1) / CPB, 1'b0)));
      check("tx_odd", 32'(tx_o), 32'(exp_bit(d, (c - 1) / CPB, 1'b1)));
      check("busy_in_frame", {busy_o, busy_e}, 2'b11);
      check("done_in_frame", {done_o, done_e}, 2'b00);
      @(negedge clk);
      load = hold;
      if (inject && c == 10) begin
        load    = 1'b1;
        data_in = '1;
      end else begin
        data_in = DW'($urandom);
      end
      @(posedge clk);
      #1;
    end
    check("done_pulse", {done_o, done_e}, 2'b11);
    check("busy_at_done", {busy_o, busy_e}, 2'b00);
    check("tx_at_done", {tx_o, tx_e}, 2'b11);
  endtask

  initial begin
    rst_n   = 1'b0;
    load    = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_tx", {tx_o, tx_e}, 2'b11);
    check("reset_busy", {busy_o, busy_e}, 2'b00);
    check("reset_done", {done_o, done_e}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);

    run_frame(6'b101101, 1'b0, 1'b0);
    idle_cycles(2);
    run_frame(6'b000111, 1'b0, 1'b0);
    idle_cycles(1);
    run_frame(6'b000011, 1'b0, 1'b0);
    idle_cycles(2);

    run_frame(DW'($urandom), 1'b0, 1'b1);
    idle_cycles(2);

    for (int i = 0; i < 4; i++) run_frame(DW'($urandom), 1'b1, 1'b0);
    idle_cycles(3);

    for (int i = 0; i < 8; i++) begin
      run_frame(DW'($urandom), 1'($urandom), 1'($urandom));
      idle_cycles(int'($urandom_range(3, 1)));
    end

    // Abort during the start bit: tx must return high at once, no resume.
    @(negedge clk);
    data_in = 6'b010101;
    load    = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_abort_tx", {tx_o, tx_e}, 2'b00);
    rst_n = 1'b0;
    #1;
    check("abort_tx", {tx_o, tx_e}, 2'b11);
    check("abort_busy", {busy_o, busy_e}, 2'b00);
    check("abort_done", {done_o, done_e}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(NCYC + 4);

    run_frame(DW'($urandom), 1'b0, 1'b0);
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
